bldc_commutator: RTL

BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

---
 rtl/motor_pkg.sv | 65 ++++++
 rtl/bldc_commutator_if.sv | 22 ++
 rtl/hall_filter.sv | 43 ++++
 rtl/bldc_commutator.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared BLDC commutation definitions: FSM encoding, six-step table and
// hall sequence indexing used by the commutator and its testbench.
package motor_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DEADTIME, ST_DRIVE, ST_FAULT} state_t;
  typedef enum logic [1:0] {PH_A, PH_B, PH_C, PH_NONE} phase_t;

  typedef struct packed {
    phase_t hi;
    phase_t lo;
  } step_t;

  localparam logic [2:0] SEQ_IDX_NONE = 3'd7;

  function automatic logic code_valid(input logic [2:0] code);
    return (code != 3'd0) && (code != 3'd7);
  endfunction

  // Forward table; reverse swaps which phase is switched high and low.
  function automatic step_t step_lookup(input logic [2:0] code, input logic rev);
    step_t s;
    s.hi = PH_NONE;
    s.lo = PH_NONE;
    case (code)
      3'd5: begin s.hi = PH_A; s.lo = PH_B; end
      3'd4: begin s.hi = PH_A; s.lo = PH_C; end
      3'd6: begin s.hi = PH_B; s.lo = PH_C; end
      3'd2: begin s.hi = PH_B; s.lo = PH_A; end
      3'd3: begin s.hi = PH_C; s.lo = PH_A; end
      3'd1: begin s.hi = PH_C; s.lo = PH_B; end
      default: ;
    endcase
    if (rev) begin
      s.hi = s.lo;
      s.lo = step_lookup_hi(code);
    end
    return s;
  endfunction

  function automatic phase_t step_lookup_hi(input logic [2:0] code);
    case (code)
      3'd5, 3'd4: return PH_A;
      3'd6, 3'd2: return PH_B;
      3'd3, 3'd1: return PH_C;
      default:    return PH_NONE;
    endcase
  endfunction

  function automatic logic [2:0] seq_index(input logic [2:0] code);
    case (code)
      3'd5:    return 3'd0;
      3'd4:    return 3'd1;
      3'd6:    return 3'd2;
      3'd2:    return 3'd3;
      3'd3:    return 3'd4;
      3'd1:    return 3'd5;
      default: return SEQ_IDX_NONE;
    endcase
  endfunction

  function automatic logic [2:0] seq_next(input logic [2:0] idx);
    return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/bldc_commutator_if.sv
// Hall inputs, drive controls, gate-driver outputs and status of the
// commutator, bundled for the controller (master) and commutator (slave).
interface bldc_commutator_if;
  logic               hall1, hall2, hall3;
  logic               pwm_in, dir, enable, clear_err;
  logic               INHA, INLA, INHB, INLB, INHC, INLC;
  logic               hall_fault, seq_error;
  logic signed [23:0] hall_count;
  logic        [23:0] step_period;

  modport master (
    output hall1, hall2, hall3, pwm_in, dir, enable, clear_err,
    input  INHA, INLA, INHB, INLB, INHC, INLC,
    input  hall_fault, seq_error, hall_count, step_period
  );

  modport slave (
    input  hall1, hall2, hall3, pwm_in, dir, enable, clear_err,
    output INHA, INLA, INHB, INLB, INHC, INLC,
    output hall_fault, seq_error, hall_count, step_period
  );
endinterface

// File: rtl/hall_filter.sv
// Two-flop synchronizer for the three hall pins followed by a stability
// filter: a code is accepted once FILTER consecutive samples agree.
module hall_filter #(
  parameter int FILTER = 64
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [2:0] hall_raw,
  output logic [2:0] code,
  output logic       code_vld
);
  localparam int CW = $clog2(FILTER + 1);

  logic [2:0]    sync1, sync2, cand;
  logic [CW-1:0] cnt, cnt_nxt;

  // cnt is the length of the current run of identical samples, capped at FILTER
  always_comb begin
    cnt_nxt = cnt;
    if ((sync2 != cand) || (cnt == '0)) cnt_nxt = CW'(1);
    else if (cnt != CW'(FILTER))        cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      cnt      <= '0;
      code     <= '0;
      code_vld <= 1'b0;
    end else begin
      sync1 <= hall_raw;
      sync2 <= sync1;
      cand  <= sync2;
      cnt   <= cnt_nxt;
      if (cnt_nxt == CW'(FILTER)) begin
        code     <= sync2;
        code_vld <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: filtered hall code selects the gate pattern,
// with dead-time between steps, fault handling and position/period tracking.
//   state       | meaning
//   ST_IDLE     | drive disabled or no valid code yet, gates off
//   ST_DEADTIME | all gates off while the dead-time down-counter runs
//   ST_DRIVE    | gates follow the latched step
//   ST_FAULT    | accepted code is 0 or 7, gates off
module bldc_commutator
  import motor_pkg::*;
#(
  parameter int DEADTIME = 32,
  parameter int FILTER   = 64
) (
  input logic               CLK,
  input logic               reset,
  bldc_commutator_if.slave  bus
);
  localparam int DW = $clog2(DEADTIME + 1);

  logic [2:0]    acc_code, code_q, step_code, step_code_nxt;
  logic          acc_vld, vld_q, step_dir, step_dir_nxt;
  logic          code_ok, code_bad, load;
  state_t        state, state_nxt;
  logic [DW-1:0] dt_cnt, dt_cnt_nxt;

  hall_filter #(.FILTER(FILTER)) u_hall_filter (
    .CLK      (CLK),
    .reset    (reset),
    .hall_raw ({bus.hall1, bus.hall2, bus.hall3}),
    .code     (acc_code),
    .code_vld (acc_vld)
  );

  assign code_ok  = acc_vld &&  code_valid(acc_code);
  assign code_bad = acc_vld && !code_valid(acc_code);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dt_cnt    <= '0;
      step_code <= '0;
      step_dir  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dt_cnt    <= dt_cnt_nxt;
      step_code <= step_code_nxt;
      step_dir  <= step_dir_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    dt_cnt_nxt    = dt_cnt;
    step_code_nxt = step_code;
    step_dir_nxt  = step_dir;
    load          = 1'b0;
    if (!bus.enable) begin
      state_nxt = ST_IDLE;
    end else if (code_bad) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE, ST_FAULT:     load = code_ok;
        ST_DRIVE, ST_DEADTIME: load = (acc_code != step_code) || (bus.dir != step_dir);
        default:               load = 1'b0;
      endcase
      // A new step (re)starts dead-time; the step to drive is latched here.
      if (load) begin
        state_nxt     = ST_DEADTIME;
        dt_cnt_nxt    = DW'(DEADTIME - 1);
        step_code_nxt = acc_code;
        step_dir_nxt  = bus.dir;
      end else if (state == ST_DEADTIME) begin
        if (dt_cnt == '0) state_nxt = ST_DRIVE;
        else              dt_cnt_nxt = dt_cnt - DW'(1);
      end
    end
  end

  step_t      st;
  logic       pwm_q;
  logic [5:0] gate_nxt, gate_q;

  assign st = step_lookup(step_code, step_dir);

  // gate bit order {INHA, INLA, INHB, INLB, INHC, INLC}
  always_comb begin
    gate_nxt = '0;
    if (state == ST_DRIVE) begin
      case (st.hi)
        PH_A:    gate_nxt[5] = pwm_q;
        PH_B:    gate_nxt[3] = pwm_q;
        PH_C:    gate_nxt[1] = pwm_q;
        default: ;
      endcase
      case (st.lo)
        PH_A:    gate_nxt[4] = 1'b1;
        PH_B:    gate_nxt[2] = 1'b1;
        PH_C:    gate_nxt[0] = 1'b1;
        default: ;
      endcase
    end
  end

  logic               change, trans, step_fwd, step_rev;
  logic [2:0]         new_idx, old_idx;
  logic               hall_fault_q, seq_error_q;
  logic signed [23:0] hall_count_q;
  logic [23:0]        step_period_q, per_cnt;

  assign change   = acc_vld && (!vld_q || (acc_code != code_q));
  assign trans    = change && vld_q && code_valid(code_q) && code_valid(acc_code);
  assign new_idx  = seq_index(acc_code);
  assign old_idx  = seq_index(code_q);
  assign step_fwd = (new_idx == seq_next(old_idx));
  assign step_rev = (old_idx == seq_next(new_idx));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pwm_q         <= 1'b0;
      gate_q        <= '0;
      code_q        <= '0;
      vld_q         <= 1'b0;
      hall_fault_q  <= 1'b0;
      seq_error_q   <= 1'b0;
      hall_count_q  <= '0;
      step_period_q <= '1;
      per_cnt       <= '0;
    end else begin
      pwm_q        <= bus.pwm_in;
      gate_q       <= gate_nxt;
      code_q       <= acc_code;
      vld_q        <= acc_vld;
      hall_fault_q <= code_bad;
      if (trans && step_fwd)      hall_count_q <= hall_count_q + 24'sd1;
      else if (trans && step_rev) hall_count_q <= hall_count_q - 24'sd1;
      if (trans && !step_fwd && !step_rev) seq_error_q <= 1'b1;
      else if (bus.clear_err)              seq_error_q <= 1'b0;
      if (trans) begin
        step_period_q <= per_cnt;
        per_cnt       <= 24'd1;
      end else if (per_cnt != '1) begin
        per_cnt <= per_cnt + 24'd1;
      end
    end
  end

  assign {bus.INHA, bus.INLA, bus.INHB, bus.INLB, bus.INHC, bus.INLC} = gate_q;
  assign bus.hall_fault  = hall_fault_q;
  assign bus.seq_error   = seq_error_q;
  assign bus.hall_count  = hall_count_q;
  assign bus.step_period = step_period_q;
endmodule
